fetch_unit: RTL and testbench

- Instruction fetch front end; supplies the 32-bit instruction stream consumed by the controller/decoder.
- Owns the PC, issues word requests to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute: flushes buffered instructions, discards in-flight responses, and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;
    localparam int                WORD_W        = 32;
    localparam logic [WORD_W-1:0] RESET_PC_DFLT = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_INSTR     = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_e;

    // Counters must hold the value BUF_DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction+pc FIFO; flush beats push and pop
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    // Upstream credit accounting guarantees a full FIFO is never pushed without a pop.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) assert (!(push_i && full_o && !do_pop));
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, credit-limited imem requester and decode-facing instruction buffer
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DFLT,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [WORD_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] instr_pc
);
    localparam int          CW      = cnt_w(BUF_DEPTH);
    localparam int unsigned DEPTH_U = BUF_DEPTH;

    state_e              state_q;
    logic [WORD_W-1:0]   pc_q, pc_d;
    logic [WORD_W-1:0]   tag_q, tag_d;
    logic [WORD_W-1:0]   target;
    logic [CW-1:0]       live_q, live_d;
    logic [CW-1:0]       drop_q, drop_d;
    logic [CW-1:0]       fifo_cnt;
    logic                fifo_full, fifo_empty;
    logic                credit, accept, rsp_ok, push, pop;
    logic [2*WORD_W-1:0] head;

    assign target = {redirect_pc[WORD_W-1:2], 2'b00};
    assign credit = (32'(live_q) + 32'(drop_q) + 32'(fifo_cnt)) < DEPTH_U;

    assign imem_req_valid = (state_q == FETCH) && credit && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    // The BOOT cycle is the first edge after reset release; stale responses there are ignored.
    assign rsp_ok         = imem_rsp_valid && (state_q != BOOT);

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instruction = instr_valid ? head[WORD_W-1:0] : NOP_INSTR;
    assign instr_pc    = instr_valid ? head[2*WORD_W-1:WORD_W] : '0;

    // Drops are always older than live requests, so they are retired first.
    always_comb begin
        live_d = live_q;
        drop_d = drop_q;
        push   = 1'b0;
        if (rsp_ok) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else if (live_q != '0) begin
                live_d = live_q - CW'(1);
                push   = !redirect_valid;
            end
        end
        if (accept) live_d = live_d + CW'(1);
        if (redirect_valid) begin
            drop_d = drop_d + live_d;
            live_d = '0;
        end
    end

    // Live requests are always a sequential run, so the tag of the next wanted word is a running PC.
    assign pc_d  = redirect_valid ? target : (accept ? pc_q + 32'd4 : pc_q);
    assign tag_d = redirect_valid ? target : (push ? tag_q + 32'd4 : tag_q);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            tag_q   <= RESET_PC;
            live_q  <= '0;
            drop_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            tag_q  <= tag_d;
            live_q <= live_d;
            drop_q <= drop_d;
            if (redirect_valid) begin
                state_q <= FETCH;
            end else begin
                case (state_q)
                    BOOT:    state_q <= FETCH;
                    FETCH:   if (!credit && instr_valid && !instr_ready) state_q <= HOLD;
                    HOLD:    if (credit) state_q <= FETCH;
                    default: state_q <= BOOT;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET && rsp_ok) assert (live_q != '0 || drop_q != '0);
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (2 * WORD_W),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i ({tag_q, imem_rsp_data}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    logic unused_full;
    assign unused_full = fifo_full;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a stream-level model
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int failures = 0;
    int rr_mode = 0;   // 0: ready always, 1: random
    int ir_mode = 1;   // 0: stall, 1: accept, 2: random
    int lat_mode = 0;  // 0: one cycle, 1: random, 2: never respond
    int cyc = 0;

    logic [31:0] mem_q [$];
    int          mem_t [$];
    bit          mem_w [$];
    int          fcount;
    logic [31:0] exp_fetch, exp_del;
    bit          hold;
    int          n_acc, deliv;
    bit          got_req, got_pop;
    logic [31:0] first_req, first_pop;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mem_q.delete(); mem_t.delete(); mem_w.delete();
        fcount = 0; exp_fetch = 32'h0; exp_del = 32'h0; hold = 0;
        n_acc = 0; got_req = 0; got_pop = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
        redirect_valid = 1'b0; instr_ready = 1'b0; imem_req_ready = 1'b1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        chk("boot_req_valid", 32'(imem_req_valid), 0);
        chk("boot_instr_valid", 32'(instr_valid), 0);
        @(negedge CLOCK);
        imem_rsp_valid = 1'b0;
        model_reset();
    endtask

    // One cycle: drive at the negedge, compare 1ns later, advance the model for the coming edge.
    task automatic step(input bit redir, input logic [31:0] tgt);
        bit acc, mpop, rsp, cred;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_req_ready = (rr_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        case (ir_mode)
            0:       instr_ready = 1'b0;
            1:       instr_ready = 1'b1;
            default: instr_ready = $urandom_range(0, 1) != 0;
        endcase
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() > 0 && mem_t[0] < cyc && lat_mode != 2 &&
            (lat_mode == 0 || $urandom_range(0, 2) == 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_q[0]);
        end
        #1;
        cred = (mem_q.size() + fcount) < DEPTH;
        chk("instr_valid", 32'(instr_valid), 32'(fcount > 0));
        if (instr_valid) begin
            chk("instr_pc", instr_pc, exp_del);
            chk("instruction", instruction, word_of(exp_del));
        end else begin
            chk("idle_instruction", instruction, 32'h0);
            chk("idle_instr_pc", instr_pc, 32'h0);
        end
        chk("req_valid", 32'(imem_req_valid), 32'(!redir && !hold && cred));
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);

        acc  = imem_req_valid && imem_req_ready;
        mpop = (fcount > 0) && instr_ready;
        rsp  = imem_rsp_valid;
        if (redir)      hold = 0;
        else if (!hold) hold = !cred && (fcount > 0) && !instr_ready;
        else            hold = !cred;
        if (acc && !got_req) begin got_req = 1; first_req = imem_req_addr; end
        if (redir) begin
            if (rsp) begin
                void'(mem_q.pop_front()); void'(mem_t.pop_front()); void'(mem_w.pop_front());
            end
            foreach (mem_w[i]) mem_w[i] = 0;
            if (acc) begin mem_q.push_back(imem_req_addr); mem_t.push_back(cyc); mem_w.push_back(0); end
            fcount = 0;
            exp_fetch = {tgt[31:2], 2'b00};
            exp_del   = {tgt[31:2], 2'b00};
            got_req = 0; got_pop = 0;
        end else begin
            if (mpop) begin
                if (!got_pop) begin got_pop = 1; first_pop = instr_pc; end
                fcount--; exp_del += 32'd4; deliv++;
            end
            if (rsp) begin
                if (mem_w[0]) fcount++;
                void'(mem_q.pop_front()); void'(mem_t.pop_front()); void'(mem_w.pop_front());
            end
            if (acc) begin
                mem_q.push_back(imem_req_addr); mem_t.push_back(cyc); mem_w.push_back(1);
                exp_fetch += 32'd4; n_acc++;
            end
        end
        cyc++;
        @(negedge CLOCK);
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int first_v;
        bit found;

        // Streaming from reset with a one-cycle memory.
        deliv = 0;
        do_reset();
        rr_mode = 0; ir_mode = 1; lat_mode = 0; first_v = 0;
        for (int k = 1; k <= 12; k++) begin
            if (instr_valid && first_v == 0) first_v = k;
            step(0, 0);
        end
        chk("a_first_valid_cycle", 32'(first_v), 3);
        chk("a_first_req", first_req, 32'h0);

        // Decode stall fills the buffer and freezes the PC.
        do_reset();
        ir_mode = 0;
        repeat (10) step(0, 0);
        chk("b_req_count", 32'(n_acc), 2);
        chk("b_req_valid", 32'(imem_req_valid), 0);
        chk("b_pc", imem_req_addr, 32'h8);
        chk("b_head_pc", instr_pc, 32'h0);
        ir_mode = 1;
        repeat (10) step(0, 0);
        chk("b_first_pop", first_pop, 32'h0);

        // Two requests in flight abandoned by a redirect.
        do_reset();
        lat_mode = 2;
        step(1, 32'h10);
        repeat (3) step(0, 0);
        chk("c_inflight", 32'(mem_q.size()), 2);
        chk("c_inflight0", mem_q[0], 32'h10);
        chk("c_inflight1", mem_q[1], 32'h14);
        step(1, 32'h40);
        lat_mode = 0;
        repeat (12) step(0, 0);
        chk("c_first_req", first_req, 32'h40);
        chk("c_got_pop", 32'(got_pop), 1);
        chk("c_first_pop", first_pop, 32'h40);

        // Redirect coinciding with a pop and a response.
        do_reset();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (instr_valid && mem_q.size() > 0 && mem_t[0] < cyc) begin
                found = 1;
                step(1, 32'h80);
                chk("d_flushed", 32'(instr_valid), 0);
            end else begin
                step(0, 0);
            end
        end
        chk("d_scenario_reached", 32'(found), 1);
        repeat (10) step(0, 0);
        chk("d_first_pop", first_pop, 32'h80);

        // Back-to-back redirects, then an unaligned target.
        step(1, 32'h100);
        step(1, 32'h200);
        repeat (10) step(0, 0);
        chk("e_first_req", first_req, 32'h200);
        chk("e_first_pop", first_pop, 32'h200);
        step(1, 32'h203);
        repeat (10) step(0, 0);
        chk("e_align_req", first_req, 32'h200);
        chk("e_align_pop", first_pop, 32'h200);

        // Random traffic, stalls and redirects.
        rr_mode = 1; ir_mode = 2; lat_mode = 1; deliv = 0;
        for (int k = 0; k < 500; k++)
            step($urandom_range(0, 19) == 0, $urandom);
        chk("f_progress", 32'(deliv > 20), 1);

        // Asynchronous reset with two live requests; late responses must be ignored.
        do_reset();
        rr_mode = 0; ir_mode = 1; lat_mode = 2;
        repeat (4) step(0, 0);
        chk("g_live", 32'(mem_q.size()), 2);
        #2;
        do_reset();
        lat_mode = 0;
        repeat (8) step(0, 0);
        chk("g_restart_req", first_req, 32'h0);
        chk("g_restart_pop", first_pop, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
